// File: rtl/qk_score_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qk_sched_pkg
// Description : Shared types and helpers for the QK score scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package qk_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam int DEFAULT_DW = 4;
    localparam int SW         = 2 * DEFAULT_DW;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int score_w(input int dw);
        return 2 * dw;
    endfunction

    // Most negative signed value of a sw-bit score; used as the masked value.
    function automatic logic [63:0] mask_min(input int sw);
        return 64'(1) << (sw - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qk_score_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : qk_sched_if
// Description : Command, engine and score-stream bundle of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface qk_sched_if
    import qk_sched_pkg::*;
#(
    parameter int NUM_HEADS = 2,
    parameter int Q_ROWS    = 3,
    parameter int SEQ_LEN   = 3,
    parameter int DW        = 4
);
    localparam int HW  = idx_w(NUM_HEADS);
    localparam int RW  = idx_w(Q_ROWS);
    localparam int SCW = score_w(DW);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [RW:0]            cmd_rows;
    logic                   cmd_causal;
    logic                   abort;
    logic                   eng_start;
    logic [HW-1:0]          eng_head;
    logic [RW-1:0]          eng_row;
    logic                   eng_done;
    logic [SEQ_LEN*SCW-1:0] eng_score;
    logic                   out_valid;
    logic                   out_ready;
    logic [HW-1:0]          out_head;
    logic [RW-1:0]          out_row;
    logic [SEQ_LEN*SCW-1:0] out_score;
    logic                   busy;
    logic                   done;
    logic                   err_timeout;

    modport slave (
        input  cmd_valid, cmd_rows, cmd_causal, abort, eng_done, eng_score, out_ready,
        output cmd_ready, eng_start, eng_head, eng_row, out_valid, out_head, out_row,
               out_score, busy, done, err_timeout
    );

    modport master (
        output cmd_valid, cmd_rows, cmd_causal, abort, eng_done, eng_score, out_ready,
        input  cmd_ready, eng_start, eng_head, eng_row, out_valid, out_head, out_row,
               out_score, busy, done, err_timeout
    );

endinterface
`default_nettype wire

// File: rtl/qk_score_scheduler_mask.sv
`default_nettype none
// ============================================================================
// Module      : qk_causal_mask
// Description : Replaces scores at key positions beyond the query row.
// Revision    : 1.0 - initial release
// ============================================================================
module qk_causal_mask
    import qk_sched_pkg::*;
#(
    parameter int SEQ_LEN = 3,
    parameter int SCW     = 8,
    parameter int RW      = 2
) (
    input  wire logic [SEQ_LEN*SCW-1:0] eng_score,
    input  wire logic [RW-1:0]          r,
    input  wire logic                   causal,
    output logic      [SEQ_LEN*SCW-1:0] masked
);
    localparam logic [SCW-1:0] MASK_VAL = SCW'(mask_min(SCW));

    for (genvar k = 0; k < SEQ_LEN; k++) begin : g_elem
        assign masked[k*SCW +: SCW] = (causal && (32'(k) > 32'(r))) ?
                                      MASK_VAL : eng_score[k*SCW +: SCW];
    end

endmodule
`default_nettype wire

// File: rtl/qk_score_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : qk_score_scheduler
// Description : Walks one qk_matmul engine over all (head, row) pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module qk_score_scheduler
    import qk_sched_pkg::*;
#(
    parameter int NUM_HEADS = 2,
    parameter int Q_ROWS    = 3,
    parameter int SEQ_LEN   = 3,
    parameter int DW        = 4,
    parameter int TIMEOUT   = 64
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    qk_sched_if.slave  bus
);
    localparam int HW  = idx_w(NUM_HEADS);
    localparam int RW  = idx_w(Q_ROWS);
    localparam int RW1 = RW + 1;
    localparam int SCW = score_w(DW);
    localparam int CW  = idx_w(TIMEOUT);

    state_e                 state_q, state_d;
    logic [HW-1:0]          h_q, h_d;
    logic [RW-1:0]          r_q, r_d;
    logic [RW:0]            rows_q, rows_d;
    logic                   causal_q, causal_d;
    logic [CW-1:0]          wait_q, wait_d;
    logic [SEQ_LEN*SCW-1:0] score_q, score_d;
    logic                   err_q, err_d;
    logic                   eng_start_q, eng_start_d;
    logic                   out_valid_q, out_valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic [SEQ_LEN*SCW-1:0] masked;
    logic                   last_row;

    qk_causal_mask #(
        .SEQ_LEN (SEQ_LEN),
        .SCW     (SCW),
        .RW      (RW)
    ) u_mask (
        .eng_score (bus.eng_score),
        .r         (r_q),
        .causal    (causal_q),
        .masked    (masked)
    );

    assign last_row = (({1'b0, r_q} + RW1'(1)) >= rows_q);

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        r_d      = r_q;
        rows_d   = rows_q;
        causal_d = causal_q;
        wait_d   = wait_q;
        score_d  = score_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (bus.cmd_rows == '0)
                        rows_d = RW1'(1);
                    else if (bus.cmd_rows > RW1'(Q_ROWS))
                        rows_d = RW1'(Q_ROWS);
                    else
                        rows_d = bus.cmd_rows;
                    causal_d = bus.cmd_causal;
                    h_d      = '0;
                    r_d      = '0;
                    err_d    = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.eng_done) begin
                    score_d = masked;
                    state_d = EMIT;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (!last_row) begin
                        r_d     = r_q + RW'(1);
                        state_d = ISSUE;
                    end else begin
                        r_d = '0;
                        if (h_q == HW'(NUM_HEADS - 1)) begin
                            state_d = FIN;
                        end else begin
                            h_d     = h_q + HW'(1);
                            state_d = ISSUE;
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a timeout in the same cycle.
        if (bus.abort) begin
            state_d = IDLE;
            err_d   = err_q;
        end

        eng_start_d = (state_d == ISSUE);
        out_valid_d = (state_d == EMIT);
        done_d      = (state_d == FIN);
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_q         <= '0;
            r_q         <= '0;
            rows_q      <= '0;
            causal_q    <= 1'b0;
            wait_q      <= '0;
            score_q     <= '0;
            err_q       <= 1'b0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            r_q         <= r_d;
            rows_q      <= rows_d;
            causal_q    <= causal_d;
            wait_q      <= wait_d;
            score_q     <= score_d;
            err_q       <= err_d;
            eng_start_q <= eng_start_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_head    = h_q;
    assign bus.eng_row     = r_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_head    = h_q;
    assign bus.out_row     = r_q;
    assign bus.out_score   = score_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;

endmodule
`default_nettype wire
